// File: rtl/hex_display_ctrl.sv
// Avalon-MM multi-digit 7-segment controller: hex or signed-decimal display with leading-zero
// blanking. Decimal values go through a sequential double-dabble converter before display.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    avs_waitrequest,
    output logic [7*NUM_DIGITS-1:0] hex_out
);
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);
    localparam int HEX_W      = 7 * NUM_DIGITS;

    localparam logic [6:0]       SEG_MINUS = 7'b0111111;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [DATA_W-1:0]       r_value;
    logic                    r_mode;
    logic                    r_blank;
    logic                    r_en;
    logic                    r_ovf;
    logic                    r_dispDec;
    logic [BCD_W-1:0]        r_bcd;
    logic [DATA_W-1:0]       r_mag;
    logic                    r_neg;
    logic [CNT_W-1:0]        r_cnt;
    logic [DISP_BCD_W-1:0]   r_decBcd;
    logic                    r_decNeg;
    logic [3:0]              r_decNd;
    logic [HEX_W-1:0]        r_hex;

    logic                    w_busy;
    logic                    w_wrAccept;
    logic                    w_wrValue;
    logic                    w_wrCtrl;
    logic                    w_launch;
    logic [DATA_W-1:0]       w_launchVal;
    logic [DATA_W-1:0]       w_launchMag;
    logic [3:0]              w_decNd;
    logic                    w_decOvf;
    logic [3:0]              w_hexNd;
    logic [31:0]             w_valExt;
    logic [HEX_W-1:0]        w_hexImg;
    logic [HEX_W-1:0]        w_decImg;
    logic [HEX_W-1:0]        w_image;

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // One double-dabble step: add-3 correction on every digit >= 5, then shift in the next bit.
    function automatic logic [BCD_W-1:0] f_ddStep(input logic [BCD_W-1:0] bcd, input logic bitIn);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bitIn};
    endfunction

    // Only value/ctrl writes stall; every accepted one happens while the converter is idle.
    assign w_busy          = (r_state != S_IDLE);
    assign avs_waitrequest = avs_write && w_busy && !avs_address[1];
    assign w_wrAccept      = avs_write && !avs_waitrequest;
    assign w_wrValue       = w_wrAccept && (avs_address == 2'd0);
    assign w_wrCtrl        = w_wrAccept && (avs_address == 2'd1);
    assign w_launch        = (w_wrValue && r_mode) || (w_wrCtrl && !r_mode && avs_writedata[0]);
    assign w_launchVal     = w_wrValue ? avs_writedata[DATA_W-1:0] : r_value;
    assign w_launchMag     = w_launchVal[DATA_W-1] ? (~w_launchVal + DATA_W'(1)) : w_launchVal;

    always_comb begin
        avs_readdata = '0;
        if (avs_read) begin
            case (avs_address)
                2'd0:    avs_readdata[DATA_W-1:0] = r_value;
                2'd1:    avs_readdata[2:0] = {r_en, r_blank, r_mode};
                2'd2:    avs_readdata[1:0] = {r_ovf, w_busy};
                default: avs_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_mode  <= 1'b0;
            r_blank <= 1'b0;
            r_en    <= 1'b1;
        end else begin
            if (w_wrValue) begin
                r_value <= avs_writedata[DATA_W-1:0];
            end
            if (w_wrCtrl) begin
                r_mode  <= avs_writedata[0];
                r_blank <= avs_writedata[1];
                r_en    <= avs_writedata[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_stateNext = S_CONV;
            S_CONV:  if (r_cnt == CNT_LAST) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_mag <= '0;
            r_neg <= 1'b0;
            r_cnt <= '0;
        end else if (w_launch) begin
            r_bcd <= '0;
            r_mag <= w_launchMag;
            r_neg <= w_launchVal[DATA_W-1];
            r_cnt <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd <= f_ddStep(r_bcd, r_mag[DATA_W-1]);
            r_mag <= {r_mag[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_decNd = 4'd1;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                w_decNd = 4'(k + 1);
            end
        end
        w_decOvf = ({1'b0, w_decNd} + {4'b0, r_neg}) > 5'(NUM_DIGITS);
    end

    // The finished decimal result is kept apart from the converter so the next conversion cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decBcd  <= '0;
            r_decNeg  <= 1'b0;
            r_decNd   <= 4'd1;
            r_ovf     <= 1'b0;
            r_dispDec <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_decBcd  <= r_bcd[DISP_BCD_W-1:0];
            r_decNeg  <= r_neg;
            r_decNd   <= w_decNd;
            r_ovf     <= w_decOvf;
            r_dispDec <= 1'b1;
        end else if (w_wrCtrl && r_mode && !avs_writedata[0]) begin
            r_ovf     <= 1'b0;
            r_dispDec <= 1'b0;
        end
    end

    always_comb begin
        w_valExt                = '0;
        w_valExt[DATA_W-1:0]    = r_value;
        w_hexNd                 = 4'd1;
        for (int k = 0; k < 8; k++) begin
            if (w_valExt[4*k +: 4] != 4'd0) begin
                w_hexNd = 4'(k + 1);
            end
        end
        w_hexImg = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_blank && (i >= int'(w_hexNd))) begin
                w_hexImg[7*i +: 7] = SEG_BLANK;
            end else begin
                w_hexImg[7*i +: 7] = f_seg(w_valExt[4*i +: 4]);
            end
        end
    end

    // Sign sits just above the MSD when blanking, otherwise in the leftmost digit.
    always_comb begin
        w_decImg = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_ovf) begin
                w_decImg[7*i +: 7] = SEG_MINUS;
            end else if (i < int'(r_decNd)) begin
                w_decImg[7*i +: 7] = f_seg(r_decBcd[4*i +: 4]);
            end else if (r_decNeg && ((r_blank && (i == int'(r_decNd))) ||
                                      (!r_blank && (i == NUM_DIGITS - 1)))) begin
                w_decImg[7*i +: 7] = SEG_MINUS;
            end else if (!r_blank) begin
                w_decImg[7*i +: 7] = SEG_ZERO;
            end else begin
                w_decImg[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    assign w_image = !r_en ? '1 : (r_dispDec ? w_decImg : w_hexImg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_image;
        end
    end

    assign hex_out = r_hex;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: register access, hex/decimal images, stall and async reset,
// with expected display images queued on a scoreboard and compared when the DUT shows them.
module tb_hex_display_ctrl;
    localparam int ND  = 6;
    localparam int DW  = 32;
    localparam int LAT = DW + 2;
    localparam int HW  = 7 * ND;

    localparam logic [6:0] T_MINUS = 7'b0111111;
    localparam logic [6:0] T_ZERO  = 7'b1000000;

    logic          clk;
    logic          rst_n;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic [HW-1:0] hex_out;

    int checks   = 0;
    int failures = 0;
    int stall;
    bit ovfModel;

    typedef struct {
        string         tag;
        logic [HW-1:0] img;
    } exp_t;

    exp_t sbQ[$];

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .hex_out         (hex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input int n);
        case (n & 15)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            10:      return 7'b0001000;
            11:      return 7'b0000011;
            12:      return 7'b1000110;
            13:      return 7'b0100001;
            14:      return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [HW-1:0] modelHex(input logic [31:0] v, input bit blank);
        logic [HW-1:0] img;
        int nd;
        nd = 1;
        for (int k = 0; k < 8; k++) begin
            if (((v >> (4 * k)) & 32'hF) != 32'h0) nd = k + 1;
        end
        for (int i = 0; i < ND; i++) begin
            if (blank && i >= nd) img[7*i +: 7] = 7'h7F;
            else img[7*i +: 7] = segOf(int'((v >> (4 * i)) & 32'hF));
        end
        return img;
    endfunction

    function automatic logic [HW-1:0] modelDec(input logic [31:0] v, input bit blank, output bit ovf);
        logic [HW-1:0] img;
        longint sv;
        longint mag;
        int dig[10];
        int nd;
        bit neg;
        sv  = longint'($signed(v));
        neg = (sv < 0);
        mag = neg ? -sv : sv;
        nd  = 1;
        for (int k = 0; k < 10; k++) begin
            dig[k] = int'(mag % 10);
            mag    = mag / 10;
            if (dig[k] != 0) nd = k + 1;
        end
        ovf = (nd + int'(neg)) > ND;
        for (int i = 0; i < ND; i++) begin
            if (ovf) img[7*i +: 7] = T_MINUS;
            else if (i < nd) img[7*i +: 7] = segOf(dig[i]);
            else if (neg && ((blank && i == nd) || (!blank && i == ND - 1))) img[7*i +: 7] = T_MINUS;
            else if (blank) img[7*i +: 7] = 7'h7F;
            else img[7*i +: 7] = T_ZERO;
        end
        return img;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expectImage(input string tag, input logic [HW-1:0] img);
        exp_t e;
        e.tag = tag;
        e.img = img;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sbQ.size() != 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_underflow observed=0 expected=1");
            return;
        end
        e = sbQ.pop_front();
        checkVal(e.tag, 64'(hex_out), 64'(e.img));
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        avs_address = addr;
        avs_read    = 1'b1;
        #1;
        data        = avs_readdata;
        avs_read    = 1'b0;
        checkVal(tag, 64'(data), 64'(exp));
    endtask

    // Holds the write until waitrequest drops (bounded), then lets one accepting edge pass.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data, output int stallCycles);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        stallCycles   = 0;
        #1;
        while (avs_waitrequest === 1'b1 && stallCycles < 200) begin
            tick();
            stallCycles++;
        end
        checkVal("write_accept_bound", 64'(avs_waitrequest), 64'(0));
        tick();
        avs_write = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b1;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checkVal("rst_hex_blank", 64'(hex_out), 64'({HW{1'b1}}));
        checkVal("rst_waitreq", 64'(avs_waitrequest), 64'(0));
        checkVal("rst_readdata_idle", 64'(avs_readdata), 64'(0));
        checkReg("rst_ctrl", 2'd1, 32'h4);
        checkReg("rst_value", 2'd0, 32'h0);
        checkReg("rst_status", 2'd2, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expectImage("post_reset_zeros", {ND{T_ZERO}});
        tick();
        checkOutput();

        // Hex mode with blanking and enable
        applyStimulus(2'd1, 32'h6, stall);
        applyStimulus(2'd0, 32'h00AB_CDEF, stall);
        expectImage("hex_abcdef", modelHex(32'h00AB_CDEF, 1'b1));
        tick();
        checkOutput();
        checkReg("value_readback", 2'd0, 32'h00AB_CDEF);
        applyStimulus(2'd0, 32'h1F, stall);
        expectImage("hex_1f_blank", modelHex(32'h1F, 1'b1));
        tick();
        checkOutput();
        applyStimulus(2'd1, 32'h4, stall);
        expectImage("hex_1f_noblank", modelHex(32'h1F, 1'b0));
        tick();
        checkOutput();
        applyStimulus(2'd1, 32'h0, stall);
        expectImage("hex_disabled", {HW{1'b1}});
        tick();
        checkOutput();
        applyStimulus(2'd1, 32'h6, stall);
        expectImage("hex_reenabled", modelHex(32'h1F, 1'b1));
        tick();
        checkOutput();
        applyStimulus(2'd2, 32'h3, stall);
        applyStimulus(2'd3, 32'h7, stall);
        checkReg("ro_status_ignored", 2'd2, 32'h0);
        checkReg("reserved_reads_zero", 2'd3, 32'h0);
        checkReg("ctrl_unchanged", 2'd1, 32'h6);

        // Switching to decimal launches a conversion of the current value
        applyStimulus(2'd1, 32'h7, stall);
        checkReg("status_busy", 2'd2, 32'h1);
        expectImage("dec31_holds_old", modelHex(32'h1F, 1'b1));
        waitCycles(LAT - 1);
        checkOutput();
        expectImage("dec31", modelDec(32'h1F, 1'b1, ovfModel));
        tick();
        checkOutput();
        checkReg("status_done", 2'd2, 32'h0);

        // Value write during conversion stalls until busy falls
        applyStimulus(2'd0, -1234, stall);
        applyStimulus(2'd0, 32'd7, stall);
        checkVal("stall_cycles", 64'(stall), 64'(DW + 1));
        expectImage("dec_m1234", modelDec(-1234, 1'b1, ovfModel));
        checkOutput();
        expectImage("dec7", modelDec(32'd7, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();

        applyStimulus(2'd0, 32'd1000000, stall);
        expectImage("dec_ovf_1e6", modelDec(32'd1000000, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();
        checkReg("status_ovf_1e6", 2'd2, 32'h2);

        // Leaving decimal mode shows hex immediately and clears overflow
        applyStimulus(2'd1, 32'h4, stall);
        expectImage("back_to_hex", modelHex(32'd1000000, 1'b0));
        tick();
        checkOutput();
        checkReg("status_ovf_cleared", 2'd2, 32'h0);
        applyStimulus(2'd0, -99999, stall);
        expectImage("hex_m99999", modelHex(-99999, 1'b0));
        tick();
        checkOutput();

        applyStimulus(2'd1, 32'h7, stall);
        expectImage("dec_m99999_fits", modelDec(-99999, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();
        checkReg("status_m99999", 2'd2, 32'h0);
        applyStimulus(2'd0, -999999, stall);
        expectImage("dec_m999999_ovf", modelDec(-999999, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();
        checkReg("status_m999999", 2'd2, 32'h2);

        // Blanking change re-renders the held decimal image without a conversion
        applyStimulus(2'd0, -42, stall);
        expectImage("dec_m42_blank", modelDec(-42, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();
        applyStimulus(2'd1, 32'h5, stall);
        expectImage("dec_m42_noblank", modelDec(-42, 1'b0, ovfModel));
        tick();
        checkOutput();
        checkReg("status_no_conv", 2'd2, 32'h0);
        applyStimulus(2'd1, 32'h7, stall);
        expectImage("dec_m42_reblank", modelDec(-42, 1'b1, ovfModel));
        tick();
        checkOutput();
        applyStimulus(2'd0, 32'd0, stall);
        expectImage("dec_zero", modelDec(32'd0, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();

        applyStimulus(2'd0, 32'h8000_0000, stall);
        expectImage("dec_min_int_ovf", modelDec(32'h8000_0000, 1'b1, ovfModel));
        waitCycles(LAT);
        checkOutput();
        checkReg("status_min_int", 2'd2, 32'h2);

        // Async reset in the middle of a conversion
        applyStimulus(2'd0, 32'h8000_0000, stall);
        waitCycles(10);
        #3 rst_n = 1'b0;
        #1;
        checkVal("midconv_rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
        checkReg("midconv_rst_status", 2'd2, 32'h0);
        checkReg("midconv_rst_ctrl", 2'd1, 32'h4);
        checkReg("midconv_rst_value", 2'd0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expectImage("post_midconv_zeros", {ND{T_ZERO}});
        tick();
        checkOutput();

        checkVal("scoreboard_drained", 64'(sbQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
